// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetch into an in-order {word, pc} queue, with redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky fetch_fault and stalls fetch.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_word [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_after;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic          fault;
  logic          issue;
  logic          resp_ok;
  logic          push;
  logic          pop;

  // Queued plus in-flight words share one credit pool, so a response always has a free slot.
  assign credit_used   = {1'b0, outstanding} + {1'b0, count};
  assign resp_ok       = mem_resp_valid && (outstanding != '0);
  assign drop_after    = outstanding - CW'(resp_ok);

  assign mem_req_valid = !reset && !redirect_valid && !fault && (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign issue         = mem_req_valid && mem_req_ready;

  assign instr_valid   = (count != '0) && !fault;
  assign instr         = instr_valid ? q_word[rd_ptr] : '0;
  assign instr_pc      = instr_valid ? q_pc[rd_ptr] : '0;

  assign push          = resp_ok && (drop == '0) && !redirect_valid;
  assign pop           = instr_valid && instr_ready && !redirect_valid;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign fetch_fault     = fault;

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault <= 1'b1;
    end
  end
`else
  logic unused_align;
  assign unused_align = ^redirect_pc[1:0];
  assign fault        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      // Responses keep retiring credits even across a redirect; only their words are discarded.
      outstanding <= outstanding + CW'(issue) - CW'(resp_ok);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= drop_after;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (resp_ok && (drop != '0)) drop <= drop - CW'(1);
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (!push && pop) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_word[wr_ptr] <= mem_resp_data;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit against a fixed-latency memory model (data = ~address).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {logic [31:0] addr; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] word;} pop_t;
  req_t mq[$];
  pop_t pops[$];

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory: accept on the rising edge, answer on the falling edge lat cycles later, in order.
  initial begin
    req_t r;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
      end else if (mem_req_valid && mem_req_ready) begin
        r.addr = mem_req_addr;
        r.due  = cyc + lat;
        mq.push_back(r);
      end
      cyc++;
      @(negedge clk);
      if (!reset && mq.size() > 0 && mq[0].due == cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = ~mq[0].addr;
        void'(mq.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end
    end
  end

  always @(posedge clk) begin
    pop_t p;
    if (!reset && instr_valid && instr_ready && !redirect_valid) begin
      p.pc   = instr_pc;
      p.word = instr;
      pops.push_back(p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; mem_req_ready = 1'b1; lat = l;
    repeat (2) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; mem_req_ready = 1'b1; lat = 1;
    repeat (2) tick();
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
    reset = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    tick();
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early_valid: got %b want 0", instr_valid); end
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin miscompares++; $display("FAIL stream_req1: got v=%b a=%h want v=1 a=4", mem_req_valid, mem_req_addr); end
    tick();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      vectors++;
      if (instr_valid !== 1'b1 || instr_pc !== e || instr !== ~e) begin
        miscompares++;
        $display("FAIL stream_word%0d: got v=%b pc=%h w=%h want v=1 pc=%h w=%h", i, instr_valid, instr_pc, instr, e, ~e);
      end
      tick();
    end
  endtask

  task automatic test_latency_cap();
    logic [7:0] exp_req;
    int base;
    exp_req = 8'b1000_1111;
    do_reset(5);
    base = pops.size();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem_req_valid !== exp_req[i] || instr_valid !== (i >= 6)) begin
        miscompares++;
        $display("FAIL cap_cycle%0d: got req=%b iv=%b want req=%b iv=%b", i, mem_req_valid, instr_valid, exp_req[i], (i >= 6));
      end
      if (i == 7) begin
        vectors++; if (mem_req_addr !== 32'h10) begin miscompares++; $display("FAIL cap_resume_addr: got %h want 10", mem_req_addr); end
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      vectors++; if (mq.size() > 4) begin miscompares++; $display("FAIL cap_inflight: got %0d want <=4", mq.size()); end
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      logic [31:0] e;
      e = 32'(4 * j);
      vectors++;
      if (pops.size() <= base + j) begin miscompares++; $display("FAIL cap_pop%0d: got none want pc=%h", j, e); end
      else if (pops[base+j].pc !== e || pops[base+j].word !== ~e) begin miscompares++; $display("FAIL cap_pop%0d: got pc=%h w=%h want pc=%h w=%h", j, pops[base+j].pc, pops[base+j].word, e, ~e); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    do_reset(1);
    instr_ready = 1'b0;
    repeat (10) tick();
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_stalled: got %b want 0", mem_req_valid); end
    vectors++; if (mq.size() != 0) begin miscompares++; $display("FAIL bp_inflight: got %0d want 0", mq.size()); end
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    base = pops.size();
    instr_ready = 1'b1;
    repeat (12) tick();
    for (int j = 0; j < 6; j++) begin
      logic [31:0] e;
      e = 32'(4 * j);
      vectors++;
      if (pops.size() <= base + j) begin miscompares++; $display("FAIL bp_pop%0d: got none want pc=%h", j, e); end
      else if (pops[base+j].pc !== e || pops[base+j].word !== ~e) begin miscompares++; $display("FAIL bp_pop%0d: got pc=%h w=%h want pc=%h w=%h", j, pops[base+j].pc, pops[base+j].word, e, ~e); end
    end
  endtask

  task automatic test_redirect();
    int base;
    do_reset(4);
    repeat (3) tick();
    vectors++; if (mq.size() != 3) begin miscompares++; $display("FAIL redir_inflight: got %0d want 3", mq.size()); end
    base = pops.size();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_no_req: got %b want 0", mem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_req: got v=%b a=%h want v=1 a=100", mem_req_valid, mem_req_addr); end
    for (int i = 4; i <= 8; i++) begin
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stale_cycle%0d: got iv=%b pc=%h want iv=0", i, instr_valid, instr_pc); end
      tick();
    end
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== ~32'h100) begin miscompares++; $display("FAIL redir_first: got v=%b pc=%h w=%h want v=1 pc=100 w=%h", instr_valid, instr_pc, instr, ~32'h100); end
    repeat (6) tick();
    for (int j = 0; j < 2; j++) begin
      logic [31:0] e;
      e = 32'h100 + 32'(4 * j);
      vectors++;
      if (pops.size() <= base + j) begin miscompares++; $display("FAIL redir_pop%0d: got none want pc=%h", j, e); end
      else if (pops[base+j].pc !== e || pops[base+j].word !== ~e) begin miscompares++; $display("FAIL redir_pop%0d: got pc=%h w=%h want pc=%h w=%h", j, pops[base+j].pc, pops[base+j].word, e, ~e); end
    end
  endtask

  task automatic test_redirect_collision();
    int base;
    do_reset(2);
    repeat (3) tick();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin miscompares++; $display("FAIL coll_pre_head: got v=%b pc=%h want v=1 pc=0", instr_valid, instr_pc); end
    base = pops.size();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL coll_flushed: got %b want 0", instr_valid); end
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin miscompares++; $display("FAIL coll_req: got v=%b a=%h want v=1 a=200", mem_req_valid, mem_req_addr); end
    repeat (3) tick();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== ~32'h200) begin miscompares++; $display("FAIL coll_first: got v=%b pc=%h w=%h want v=1 pc=200 w=%h", instr_valid, instr_pc, instr, ~32'h200); end
    repeat (4) tick();
    for (int j = 0; j < 2; j++) begin
      logic [31:0] e;
      e = 32'h200 + 32'(4 * j);
      vectors++;
      if (pops.size() <= base + j) begin miscompares++; $display("FAIL coll_pop%0d: got none want pc=%h", j, e); end
      else if (pops[base+j].pc !== e || pops[base+j].word !== ~e) begin miscompares++; $display("FAIL coll_pop%0d: got pc=%h w=%h want pc=%h w=%h", j, pops[base+j].pc, pops[base+j].word, e, ~e); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset(3);
    repeat (2) tick();
    base = pops.size();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500) begin miscompares++; $display("FAIL b2b_req: got v=%b a=%h want v=1 a=500", mem_req_valid, mem_req_addr); end
    repeat (4) tick();
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h500 || instr !== ~32'h500) begin miscompares++; $display("FAIL b2b_first: got v=%b pc=%h w=%h want v=1 pc=500 w=%h", instr_valid, instr_pc, instr, ~32'h500); end
    repeat (3) tick();
    vectors++;
    if (pops.size() <= base) begin miscompares++; $display("FAIL b2b_pop0: got none want pc=500"); end
    else if (pops[base].pc !== 32'h500 || pops[base].word !== ~32'h500) begin miscompares++; $display("FAIL b2b_pop0: got pc=%h w=%h want pc=500 w=%h", pops[base].pc, pops[base].word, ~32'h500); end
  endtask

  task automatic test_misaligned();
    int base;
    do_reset(1);
    repeat (3) tick();
    base = pops.size();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    vectors++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL align_fault: got f=%b req=%b want f=1 req=0", fetch_fault, mem_req_valid); end
    repeat (5) tick();
    vectors++; if (fetch_fault !== 1'b1 || mem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL align_sticky: got f=%b req=%b iv=%b want 1 0 0", fetch_fault, mem_req_valid, instr_valid); end
    vectors++; if (pops.size() != base) begin miscompares++; $display("FAIL align_no_pop: got %0d pops want 0", pops.size() - base); end
`else
    vectors++; if (fetch_fault !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin miscompares++; $display("FAIL align_masked: got f=%b v=%b a=%h want f=0 v=1 a=100", fetch_fault, mem_req_valid, mem_req_addr); end
    repeat (5) tick();
    vectors++;
    if (pops.size() <= base) begin miscompares++; $display("FAIL align_pop0: got none want pc=100"); end
    else if (pops[base].pc !== 32'h100 || pops[base].word !== ~32'h100) begin miscompares++; $display("FAIL align_pop0: got pc=%h w=%h want pc=100 w=%h", pops[base].pc, pops[base].word, ~32'h100); end
`endif
  endtask

  task automatic test_wrap();
    int base;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    do_reset(1);
    repeat (2) tick();
    base = pops.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_pc[i]) begin miscompares++; $display("FAIL wrap_req%0d: got v=%b a=%h want v=1 a=%h", i, mem_req_valid, mem_req_addr, exp_pc[i]); end
      tick();
    end
    repeat (4) tick();
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (pops.size() <= base + j) begin miscompares++; $display("FAIL wrap_pop%0d: got none want pc=%h", j, exp_pc[j]); end
      else if (pops[base+j].pc !== exp_pc[j] || pops[base+j].word !== ~exp_pc[j]) begin miscompares++; $display("FAIL wrap_pop%0d: got pc=%h w=%h want pc=%h w=%h", j, pops[base+j].pc, pops[base+j].word, exp_pc[j], ~exp_pc[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency_cap();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction prefetch stage sitting directly upstream of the single-cycle core's decode path. It issues sequential word fetches to a variable-latency instruction memory port and buffers returned words with their PCs in a small in-order queue. Decode consumes the queue through a valid/ready handshake. A redirect from the branch unit flushes the queue, discards in-flight responses, and restarts fetch at the target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2; also the cap on queued plus in-flight words
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word address of request; bits [1:0] always 0
- mem_resp_valid  in  1  one response word this cycle; in request order; no backpressure
- mem_resp_data  in  32  response word
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction word
- instr_pc  out  32  PC of head word
- redirect_valid  in  1  flush and restart
- redirect_pc  in  32  restart address
- fetch_fault  out  1  misaligned redirect flag (see Configuration)

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next kept response), queue (DEPTH × {word, pc}), count (0..DEPTH), outstanding (0..DEPTH), drop (0..DEPTH). Counters are $clog2(DEPTH)+1 bits wide.
- Issue: mem_req_valid = !reset && !redirect_valid && (outstanding + count < DEPTH). mem_req_addr = fetch_pc. On mem_req_valid && mem_req_ready, fetch_pc += 4 (mod 2^32) and outstanding++.
- Response: each mem_resp_valid decrements outstanding.
  - If drop > 0, discard the word and decrement drop.
  - Otherwise push {mem_resp_data, resp_pc} and advance resp_pc by 4.
  - The credit rule guarantees the queue never overflows. A response with outstanding == 0 is a protocol error and is ignored.
- Consume: instr_valid = (count != 0). On instr_valid && instr_ready, pop the head.
- Simultaneous push and pop: count unchanged.
- Redirect (highest priority, same cycle):
  - queue cleared (count <= 0); any pop is ignored.
  - fetch_pc <= resp_pc <= redirect_pc.
  - drop <= drop_after, where drop_after = outstanding − mem_resp_valid.
  - No request is issued in the redirect cycle. A response arriving that cycle is discarded.
- Back-to-back redirects: each one reloads drop from the live outstanding count. No stale word is ever delivered.

## Timing
- Reset values:
  - fetch_pc = resp_pc = RESET_PC.
  - count = outstanding = drop = 0.
  - mem_req_valid = 0, instr_valid = 0, fetch_fault = 0, instr = 0, instr_pc = 0.
- First request is asserted in the first cycle after reset deasserts.
- Response to instr_valid latency: 1 cycle; the word is registered into the queue, with no bypass.
- Redirect to new request: the request is asserted in the cycle after redirect_valid. The first kept word appears 1 cycle after its response.
- Throughput: 1 word/cycle sustained when memory latency < DEPTH cycles and decode is always ready.
- Wrap-around: fetch_pc 32'hFFFFFFFC → 32'h0.
- Reset asserted mid-operation overrides everything. In-flight responses arriving after reset are ignored via outstanding == 0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault, which stays high until reset.
  - While fetch_fault is high, mem_req_valid = 0 and instr_valid = 0.
- Undefined:
  - redirect_pc[1:0] is forced to 0.
  - fetch_fault is tied 0.

## Test plan
- Reset, memory with 1-cycle latency, instr_ready=1 → requests at 0,4,8…; instr_pc 0,4,8 delivered one per cycle; first instr_valid 2 cycles after the first request handshake.
- Memory with 5-cycle latency, DEPTH=4 → outstanding+count never exceeds 4; mem_req_valid drops when the cap is reached.
- instr_ready=0 for 10 cycles → count saturates at 4, no overflow; on release, words 0,4,8,12 come out in order.
- 3 responses in flight, redirect_pc=32'h100 → the 3 stale words are dropped; next instr_pc=32'h100 with the word from 32'h100.
- Redirect in the same cycle as a response and a pop → queue empty next cycle; drop = outstanding−1; no stale word delivered.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=32'h102 → fetch_fault=1, requests stop; without the macro, fetch restarts at 32'h100.
